// File: rtl/cacheline_adapter.sv
// Bridges a cache-line request to a multi-beat memory burst: it assembles read beats into a line
// and serialises a write-back line into beats.
module cacheline_adapter #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  output logic                resp_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  output logic [s_burst-1:0]  burst_o,
  input  logic [s_burst-1:0]  burst_i,
  input  logic                resp_i
);

  localparam int unsigned Beats = s_line / s_burst;
  localparam int unsigned CntW  = $clog2(Beats);
  localparam int unsigned OffW  = $clog2(s_line / 8);
  localparam logic [31:0]     AddrMask = ~((32'd1 << OffW) - 32'd1);
  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                      state_q;
  logic [CntW-1:0]             cnt_q;
  logic [31:0]                 addr_q;
  logic [Beats-1:0][s_burst-1:0] line_q;
  logic [Beats-1:0][s_burst-1:0] wline_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      wline_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          // Read wins when both requests are raised together.
          if (read_i) begin
            state_q <= StRead;
            addr_q  <= address_i & AddrMask;
          end else if (write_i) begin
            state_q <= StWrite;
            addr_q  <= address_i & AddrMask;
            wline_q <= line_i;
          end
        end
        StRead: begin
          if (resp_i) begin
            line_q[cnt_q] <= burst_i;
            cnt_q         <= cnt_q + 1'b1;
            if (cnt_q == LastBeat) state_q <= StDone;
          end
        end
        StWrite: begin
          if (resp_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastBeat) state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode directly from registered state, so they carry no combinational input paths.
  assign line_o    = line_q;
  assign address_o = addr_q;
  assign read_o    = (state_q == StRead);
  assign write_o   = (state_q == StWrite);
  assign resp_o    = (state_q == StDone);
  assign burst_o   = wline_q[cnt_q];

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: a driver queues expected line results and a monitor
// checks them whenever resp_o pulses; a responder plays the memory side.
module tb_cacheline_adapter;

  localparam int NB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i, write_i;
  logic [255:0] line_i, line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o, write_o;
  logic [63:0]  burst_o, burst_i;
  logic         resp_i;

  always #5 clk = ~clk;

  cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  typedef struct {
    bit           is_read;
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  exp_t         exp_q[$];
  logic [63:0]  wbeats[$];
  logic [63:0]  wtrace[$];
  bit           pat_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           resp_mode = 0;
  int           rd_cyc = 0;
  int           wr_cyc = 0;
  logic [255:0] fill_line = '0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory side: serves fill beats in order and strobes resp_i per the selected mode.
  initial begin : responder
    int rb;
    rb = 0;
    resp_i = 1'b0;
    burst_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!read_o) rb = 0;
      case (resp_mode)
        0: resp_i = ($urandom_range(0, 2) != 0);
        1: resp_i = 1'b1;
        default: begin
          if ((read_o || write_o) && pat_q.size() > 0) resp_i = pat_q.pop_front();
          else resp_i = 1'b1;
        end
      endcase
      if (read_o && resp_i && rb < NB) begin
        burst_i = fill_line[rb*64 +: 64];
        rb++;
      end else begin
        burst_i = {$urandom, $urandom};
      end
    end
  end

  initial begin : monitor
    exp_t         e;
    logic [255:0] got;
    forever begin
      @(negedge clk);
      if (rst) begin
        wbeats.delete();
        continue;
      end
      if (read_o) rd_cyc++;
      if (write_o) wr_cyc++;
      if (read_o || write_o) chk("rw_exclusive", {255'd0, read_o & write_o}, '0);
      if (write_o) begin
        wtrace.push_back(burst_o);
        if (resp_i) wbeats.push_back(burst_o);
      end
      if (resp_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 256'd1, 256'd0);
        end else begin
          e = exp_q.pop_front();
          chk("address_o", {224'd0, address_o}, {224'd0, e.addr});
          if (e.is_read) begin
            chk("read_line", line_o, e.line);
            chk("read_no_write_beats", 256'(wbeats.size()), 256'd0);
          end else begin
            chk("write_beat_count", 256'(wbeats.size()), 256'(NB));
            got = '0;
            for (int i = 0; i < wbeats.size() && i < NB; i++) got[i*64 +: 64] = wbeats[i];
            chk("write_line", got, e.line);
          end
        end
        wbeats.delete();
      end
    end
  end

  // kind: 0 read, 1 write, 2 read and write together.
  task automatic do_txn(input int kind, input logic [31:0] addr, input logic [255:0] wl,
                        input logic [255:0] fill, output int lat);
    exp_t e;
    fill_line = fill;
    address_i = addr;
    line_i    = wl;
    read_i    = (kind != 1);
    write_i   = (kind != 0);
    e.is_read = (kind != 1);
    e.addr    = addr & ~32'h1f;
    e.line    = e.is_read ? fill : wl;
    exp_q.push_back(e);
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (resp_o) break;
      if (read_o || write_o) begin
        address_i = $urandom;
        line_i    = rand_line();
      end
      if (lat > 200) begin
        chk("txn_timeout", 256'(lat), 256'd0);
        break;
      end
    end
    read_i  = 1'b0;
    write_i = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : driver
    int           lat;
    logic [255:0] fill, wl;
    logic [63:0]  d[4];
    logic [63:0]  exp_tr[$];

    rst = 1'b1;
    address_i = '0;
    read_i = 1'b0;
    write_i = 1'b0;
    line_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_read_o", {255'd0, read_o}, '0);
    chk("reset_write_o", {255'd0, write_o}, '0);
    chk("reset_resp_o", {255'd0, resp_o}, '0);
    chk("reset_line_o", line_o, '0);
    chk("reset_address_o", {224'd0, address_o}, '0);
    chk("reset_burst_o", {192'd0, burst_o}, '0);

    // Directed line fill at minimum latency.
    idle(2);
    resp_mode = 1;
    rd_cyc = 0;
    fill = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_txn(0, 32'h0000_1234, '0, fill, lat);
    chk("read_latency", 256'(lat), 256'(NB + 1));
    chk("read_addr_aligned", {224'd0, address_o}, {224'd0, 32'h0000_1220});
    chk("read_o_cycles", 256'(rd_cyc), 256'(NB));

    // Directed write-back with gaps between beats.
    idle(2);
    for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
    wl = {d[3], d[2], d[1], d[0]};
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    resp_mode = 2;
    wtrace.delete();
    do_txn(1, 32'h8000_0047, wl, '0, lat);
    chk("write_latency", 256'(lat), 256'd8);
    chk("write_o_low_at_resp", {255'd0, write_o}, '0);
    exp_tr = '{d[0], d[1], d[1], d[1], d[2], d[3], d[3]};
    chk("write_trace_len", 256'(wtrace.size()), 256'(exp_tr.size()));
    for (int i = 0; i < exp_tr.size() && i < wtrace.size(); i++)
      chk("write_trace_beat", {192'd0, wtrace[i]}, {192'd0, exp_tr[i]});

    // resp_i held high through DONE and IDLE must not disturb anything.
    resp_mode = 1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("idle_read_o", {255'd0, read_o}, '0);
      chk("idle_write_o", {255'd0, write_o}, '0);
      chk("idle_line_hold", line_o, fill);
      chk("idle_counter_zero", {192'd0, burst_o}, {192'd0, d[0]});
    end

    // Simultaneous read and write request: read only.
    idle(2);
    rd_cyc = 0;
    wr_cyc = 0;
    fill = rand_line();
    do_txn(2, $urandom, rand_line(), fill, lat);
    chk("both_write_o_cycles", 256'(wr_cyc), 256'd0);
    chk("both_read_o_cycles", 256'(rd_cyc), 256'(NB));

    // Reset after two read beats abandons the fill.
    idle(2);
    fill_line = rand_line();
    address_i = $urandom;
    read_i = 1'b1;
    idle(3);
    rst = 1'b1;
    read_i = 1'b0;
    idle(1);
    rst = 1'b0;
    chk("rst_mid_read_o", {255'd0, read_o}, '0);
    chk("rst_mid_line_o", line_o, '0);
    chk("rst_mid_resp_o", {255'd0, resp_o}, '0);
    idle(3);
    fill = rand_line();
    do_txn(0, $urandom, '0, fill, lat);
    chk("post_rst_latency", 256'(lat), 256'(NB + 1));

    // Randomised traffic with random beat gaps.
    resp_mode = 0;
    for (int t = 0; t < 40; t++) begin
      idle($urandom_range(0, 2));
      do_txn($urandom_range(0, 2), $urandom, rand_line(), rand_line(), lat);
    end

    idle(5);
    chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 SHALL have parameter s_line, default 256, meaning cache line width in bits.
REQ-002 SHALL have parameter s_burst, default 64, meaning memory beat width in bits; BEATS = s_line/s_burst, a power of two >= 2 (4 by default).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port address_i  input  32  cache-side line address.
REQ-006 SHALL have port read_i  input  1  cache line-fill request, held until resp_o.
REQ-007 SHALL have port write_i  input  1  cache write-back request, held until resp_o.
REQ-008 SHALL have port line_i  input  s_line  write-back line data.
REQ-009 SHALL have port line_o  output  s_line  assembled fill line.
REQ-010 SHALL have port resp_o  output  1  one-cycle completion pulse to the cache.
REQ-011 SHALL have port address_o  output  32  memory-side burst address.
REQ-012 SHALL have port read_o  output  1  memory burst-read request.
REQ-013 SHALL have port write_o  output  1  memory burst-write request.
REQ-014 SHALL have port burst_o  output  s_burst  outgoing write beat.
REQ-015 SHALL have port burst_i  input  s_burst  incoming read beat.
REQ-016 SHALL have port resp_i  input  1  memory beat-valid/accept strobe, one beat per high cycle.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, DONE, with a beat counter of log2(BEATS) bits.
REQ-018 In IDLE: read_i high -> READ; else write_i high -> WRITE; read_i and write_i both high -> READ (read priority); neither -> stay.
REQ-019 On leaving IDLE SHALL register address_i with bits [log2(s_line/8)-1:0] forced to zero, clear counter; on WRITE entry SHALL also register line_i.
REQ-020 address_o SHALL drive the registered aligned address whenever state is READ or WRITE; it holds its last value otherwise.
REQ-021 read_o SHALL be high exactly while state is READ; write_o SHALL be high exactly while state is WRITE; both low in IDLE and DONE.
REQ-022 In READ, each cycle with resp_i high SHALL store burst_i into line_o[(k+1)*s_burst-1 : k*s_burst] (k = counter; beat 0 = least significant) and increment the counter.
REQ-023 In WRITE, burst_o SHALL equal registered line slice k combinationally; each cycle with resp_i high SHALL advance k.
REQ-024 Cycles with resp_i low in READ/WRITE SHALL hold counter and data (gaps between beats allowed).
REQ-025 The resp_i cycle with k = BEATS-1 SHALL transition to DONE; counter wraps to 0.
REQ-026 In DONE, resp_o SHALL be high for exactly that one cycle, then -> IDLE unconditionally.
REQ-027 line_o SHALL be stable and complete during resp_o and SHALL hold until the next READ beat overwrites it.
REQ-028 Minimum request-to-resp_o latency SHALL be BEATS+1 cycles after the IDLE sampling edge (5 by default, resp_i high every cycle).
REQ-029 resp_i in IDLE or DONE SHALL be ignored; read_i/write_i/address_i/line_i changes outside IDLE SHALL be ignored.

Reset
REQ-030 rst high at a rising edge SHALL force state IDLE, counter 0, resp_o 0, read_o 0, write_o 0, line_o 0, address_o 0, registered write line 0, regardless of state.
REQ-031 Reset mid-burst SHALL abandon the transaction without resp_o; the first post-reset edge with read_i/write_i high SHALL start a new transaction.

Verification
REQ-032 Read: address_i=0x0000_1234, read_i=1, resp_i high 4 consecutive cycles with burst_i=0x11..11,0x22..22,0x33..33,0x44..44 -> address_o=0x0000_1220, read_o high 4 cycles, resp_o one cycle later, line_o = {0x44..44,0x33..33,0x22..22,0x11..11}.
REQ-033 Write: line_i={D3,D2,D1,D0}, write_i=1, resp_i pattern 1,0,0,1,1,0,1 -> burst_o D0,D1,D1,D1,D2,D3,D3 on those cycles, write_o low and resp_o pulse after 7th cycle.
REQ-034 read_i=write_i=1 in IDLE -> read_o high, write_o never high, line fill performed.
REQ-035 rst asserted after 2 read beats -> next cycle read_o=0, resp_o never pulses; a new read then completes with 4 fresh beats and correct line_o.
REQ-036 resp_i held high in IDLE and DONE for 3 cycles -> no state change, counter stays 0, line_o unchanged.
